// File: rtl/sat_trail_stack_pkg.sv
// sat_trail_stack_pkg: shared types and width helpers for the SAT trail stack
package sat_trail_stack_pkg;
  localparam int LW_MAX = 8;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_BT} trail_op;
  typedef enum logic {IDLE, BT} bt_state;
  typedef struct packed {
    logic [LW_MAX-1:0] num;
    logic              val;
    logic              dec;
  } trail_entry;
  function automatic int lw_of(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int cw_of(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/sat_trail_mem.sv
// sat_trail_mem: DEPTH-entry trail storage, one write port, combinational read, contents not reset
module sat_trail_mem
  import sat_trail_stack_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trail_entry    wdata,
  input  logic [AW-1:0] raddr,
  output trail_entry    rdata
);
  trail_entry mem [DEPTH];
  // write the pushed entry
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = raddr < AW'(DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/sat_trail_stack.sv
// sat_trail_stack: SAT solver assignment trail with push/pop/backtrack-to-decision; optional TRAIL_DUP_CHECK_EN rejects pushes of assigned variables
module sat_trail_stack
  import sat_trail_stack_pkg::*;
#(
  parameter  int NUM_LITERALS = 5,
  parameter  int DEPTH        = NUM_LITERALS,
  localparam int LW           = lw_of(NUM_LITERALS),
  localparam int CW           = cw_of(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [LW-1:0]           cmd_num,
  input  logic                    cmd_val,
  input  logic                    cmd_dec,
  output logic [LW-1:0]           top_num,
  output logic                    top_val,
  output logic                    top_dec,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output logic [NUM_LITERALS-1:0] assigned,
  output logic [NUM_LITERALS-1:0] value,
  output logic                    bt_done,
  output logic                    bt_found,
  output logic [LW-1:0]           bt_num,
  output logic                    bt_val,
  output logic                    err_overflow,
  output logic                    err_underflow
);
  bt_state state, nxt;
  trail_op op;
  trail_entry top, wr;
  logic accept, dup, bad_push, do_push, do_pop, bt_end;
  logic [NUM_LITERALS-1:0] psel, tsel;
  assign op      = trail_op'(cmd_op);
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign top_num = top.num[LW-1:0];
  assign top_val = top.val;
  assign top_dec = top.dec;
  assign wr      = '{num: LW_MAX'(cmd_num), val: cmd_val, dec: cmd_dec};
  assign psel    = NUM_LITERALS'(1) << (cmd_num - LW'(1));
  assign tsel    = NUM_LITERALS'(1) << (top.num - LW_MAX'(1));
  assign accept  = cmd_valid && cmd_ready;
  assign bt_end  = empty || top.dec || count == CW'(1);
`ifdef TRAIL_DUP_CHECK_EN
  assign dup = |(assigned & psel);
`else
  assign dup = 1'b0;
`endif
  sat_trail_mem #(.DEPTH(DEPTH), .AW(CW)) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(count),
    .wdata(wr),
    .raddr(count - CW'(1)),
    .rdata(top)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // leave BT once a decision or the bottom of the trail has been popped
  always_comb begin
    nxt = state == IDLE ? ((accept && op == OP_BT) ? BT : IDLE) : (bt_end ? IDLE : BT);
  end
  // command decode: BT pops one entry per cycle while commands are stalled
  always_comb begin
    cmd_ready = state == IDLE;
    bad_push  = cmd_num == '0 || cmd_num > LW'(NUM_LITERALS) || full || dup;
    do_push   = accept && op == OP_PUSH && !bad_push;
    do_pop    = !empty && (state == BT || (accept && op == OP_POP));
  end
  // occupancy and per-variable assignment map
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      assigned <= '0;
      value    <= '0;
    end else if (do_push) begin
      count    <= count + CW'(1);
      assigned <= assigned | psel;
      value    <= (value & ~psel) | (cmd_val ? psel : '0);
    end else if (do_pop) begin
      count    <= count - CW'(1);
      assigned <= assigned & ~tsel;
      value    <= value & ~tsel;
    end
  end
  // backtrack result capture and single-cycle error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bt_done       <= 1'b0;
      bt_found      <= 1'b0;
      bt_num        <= '0;
      bt_val        <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      bt_done       <= state == BT && bt_end;
      err_overflow  <= accept && op == OP_PUSH && bad_push;
      err_underflow <= accept && op == OP_POP && empty;
      if (state == BT && bt_end) begin
        bt_found <= !empty && top.dec;
        bt_num   <= (!empty && top.dec) ? top.num[LW-1:0] : '0;
        bt_val   <= !empty && top.dec && !top.val;
      end
    end
  end
endmodule

// File: tb/tb_sat_trail_stack.sv
// tb_sat_trail_stack: directed self-checking bench with a backtrack-result scoreboard
module tb_sat_trail_stack;
  localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, BTK = 2'd3;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_num = 0, top_num, bt_num, count;
  logic cmd_val = 0, cmd_dec = 0, top_val, top_dec, full, empty;
  logic [4:0] assigned, value;
  logic bt_done, bt_found, bt_val, err_overflow, err_underflow;
  int total = 0, bad = 0;
  typedef struct {logic found; logic [2:0] num; logic val; int lat;} bt_exp_t;
  bt_exp_t bt_q[$];

  sat_trail_stack #(.NUM_LITERALS(5), .DEPTH(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_num(cmd_num), .cmd_val(cmd_val), .cmd_dec(cmd_dec), .top_num(top_num),
    .top_val(top_val), .top_dec(top_dec), .count(count), .full(full), .empty(empty),
    .assigned(assigned), .value(value), .bt_done(bt_done), .bt_found(bt_found),
    .bt_num(bt_num), .bt_val(bt_val), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] n, input logic v, input logic d);
    cmd_valid = 1; cmd_op = op; cmd_num = n; cmd_val = v; cmd_dec = d;
    tick();
    cmd_valid = 0; cmd_op = NOP; cmd_num = 0; cmd_val = 0; cmd_dec = 0;
  endtask

  task automatic bt_run(input logic f, input logic [2:0] n, input logic v, input int lat);
    bt_exp_t e;
    int cyc, low;
    bt_q.push_back('{found: f, num: n, val: v, lat: lat});
    issue(BTK, 0, 0, 0);
    cyc = 0; low = 0;
    while (bt_done !== 1'b1 && cyc < 20) begin
      if (cmd_ready === 1'b0) low++;
      tick();
      cyc++;
    end
    e = bt_q.pop_front();
    chk("bt_latency", cyc, e.lat);
    chk("bt_ready_low", low, e.lat);
    chk("bt_found", bt_found, e.found);
    chk("bt_num", bt_num, e.num);
    chk("bt_val", bt_val, e.val);
    tick();
    chk("bt_done_pulse", bt_done, 0);
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", {empty, full}, 2'b10);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_maps", {assigned, value}, 0);
    chk("rst_top", {top_num, top_val, top_dec}, 0);
    chk("rst_bt", {bt_done, bt_found, bt_num, bt_val}, 0);
    chk("rst_err", {err_overflow, err_underflow}, 0);
    issue(PUSH, 3, 1, 1);
    issue(PUSH, 1, 0, 0);
    chk("push2_count", count, 2);
    chk("push2_top", {top_num, top_val, top_dec}, {3'd1, 1'b0, 1'b0});
    chk("push2_assigned", assigned, 5'b00101);
    chk("push2_value", value, 5'b00100);
    issue(POP, 0, 0, 0);
    chk("pop_count", count, 1);
    chk("pop_top", {top_num, top_val, top_dec}, {3'd3, 1'b1, 1'b1});
    chk("pop_maps", {assigned, value}, {5'b00100, 5'b00100});
    issue(POP, 0, 0, 0);
    chk("pop2_empty", {count, empty}, {3'd0, 1'b1});
    chk("pop2_maps", {assigned, value}, 0);
    for (int i = 1; i <= 5; i++) issue(PUSH, 3'(i), i[0], 0);
    chk("fill_full", {count, full, empty}, {3'd5, 1'b1, 1'b0});
    chk("fill_maps", {assigned, value}, {5'b11111, 5'b10101});
    issue(PUSH, 2, 1, 0);
    chk("ovf_pulse", err_overflow, 1);
    chk("ovf_count", count, 5);
    tick();
    chk("ovf_once", err_overflow, 0);
    chk("ovf_full", full, 1);
    bt_run(0, 0, 0, 5);
    chk("bt5_count", count, 0);
    issue(PUSH, 0, 1, 0);
    chk("num0_ovf", {err_overflow, count}, {1'b1, 3'd0});
    issue(PUSH, 6, 1, 0);
    chk("num6_ovf", {err_overflow, count}, {1'b1, 3'd0});
    issue(PUSH, 2, 1, 1);
    issue(PUSH, 4, 0, 0);
    issue(PUSH, 5, 1, 0);
    bt_run(1, 2, 0, 3);
    chk("bt3_count", count, 0);
    chk("bt3_assigned", assigned, 0);
    issue(PUSH, 1, 1, 0);
    issue(PUSH, 2, 0, 0);
    chk("hold_found", {bt_found, bt_num, bt_val}, {1'b1, 3'd2, 1'b0});
    bt_run(0, 0, 0, 2);
    bt_run(0, 0, 0, 1);
    issue(POP, 0, 0, 0);
    chk("udf_pulse", {err_underflow, count}, {1'b1, 3'd0});
    tick();
    chk("udf_once", err_underflow, 0);
    issue(PUSH, 1, 0, 1);
    issue(PUSH, 2, 1, 0);
    issue(PUSH, 3, 0, 1);
    issue(PUSH, 4, 1, 0);
    bt_run(1, 3, 1, 2);
    chk("mid_count", count, 2);
    chk("mid_maps", {assigned, value}, {5'b00011, 5'b00010});
    bt_run(1, 1, 1, 2);
    chk("mid2_count", count, 0);
    for (int i = 1; i <= 4; i++) issue(PUSH, 3'(i), 1, 0);
    issue(BTK, 0, 0, 0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_count", count, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", {bt_done, bt_found}, 0);
    tick();
    chk("abort_done2", bt_done, 0);
`ifdef TRAIL_DUP_CHECK_EN
    issue(PUSH, 3, 1, 0);
    issue(PUSH, 3, 0, 0);
    chk("dup_ovf", err_overflow, 1);
    chk("dup_count", count, 1);
    chk("dup_maps", {assigned, value}, {5'b00100, 5'b00100});
    issue(POP, 0, 0, 0);
`else
    issue(PUSH, 3, 1, 0);
    issue(PUSH, 3, 0, 0);
    chk("dup_ovf", err_overflow, 0);
    chk("dup_count", count, 2);
    chk("dup_maps", {assigned, value}, {5'b00100, 5'b00000});
    issue(POP, 0, 0, 0);
    chk("dup_pop_maps", {count, assigned}, {3'd1, 5'b00000});
    issue(POP, 0, 0, 0);
`endif
    cmd_op = PUSH; cmd_num = 2; cmd_val = 1;
    tick();
    cmd_op = NOP; cmd_num = 0; cmd_val = 0;
    chk("novalid_count", count, 0);
    issue(NOP, 2, 1, 0);
    chk("nop_state", {count, assigned, err_overflow, err_underflow}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sat_trail_stack.md
SAT_TRAIL_STACK -- requirements
Module: sat_trail_stack

Interface
REQ-001 SHALL have parameter NUM_LITERALS, default 5, number of variables; variable ids are 1..NUM_LITERALS and 0 is null.
REQ-002 SHALL have parameter DEPTH, default NUM_LITERALS, trail capacity in entries.
REQ-003 SHALL use LW = $clog2(NUM_LITERALS+1) for literal id width and CW = $clog2(DEPTH+1) for count width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command strobe; cmd_ready  out  1  command accept.
REQ-008 cmd_op  in  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 BACKTRACK.
REQ-009 cmd_num  in  LW  and  cmd_val  in  1  literal to push; cmd_dec  in  1  marks the pushed entry as a decision.
REQ-010 top_num  out  LW,  top_val  out  1,  top_dec  out  1  top entry; all zero when empty.
REQ-011 count  out  CW,  full  out  1,  empty  out  1  occupancy.
REQ-012 assigned  out  NUM_LITERALS  and  value  out  NUM_LITERALS; bit i describes variable i+1.
REQ-013 bt_done  out  1,  bt_found  out  1,  bt_num  out  LW,  bt_val  out  1  backtrack result.
REQ-014 err_overflow  out  1  and  err_underflow  out  1  single-cycle error pulses.

Function
REQ-015 A command SHALL be accepted only on a cycle where cmd_valid and cmd_ready are both high.
REQ-016 The FSM SHALL have two states, IDLE and BT; cmd_ready SHALL be high in IDLE and low in BT.
REQ-017 An accepted PUSH with count<DEPTH SHALL, at that edge, write {cmd_num, cmd_val, cmd_dec}, increment count, set assigned[cmd_num-1], and set value[cmd_num-1]=cmd_val.
REQ-018 An accepted PUSH when full SHALL leave all state unchanged and pulse err_overflow for one cycle.
REQ-019 An accepted POP when not empty SHALL remove the top entry, decrement count, and clear both assigned and value for that variable.
REQ-020 An accepted POP when empty SHALL leave state unchanged and pulse err_underflow.
REQ-021 An accepted BACKTRACK SHALL move IDLE->BT; each BT cycle SHALL pop exactly one entry, as in REQ-019.
REQ-022 BT SHALL exit to IDLE when the popped entry has dec=1: bt_found=1, bt_num=popped num, bt_val=NOT popped val.
REQ-023 BT SHALL exit to IDLE with bt_found=0 and bt_num=0 when count reaches 0 without popping a decision.
REQ-024 BACKTRACK on an empty trail SHALL spend one BT cycle popping nothing, then report bt_found=0.
REQ-025 bt_done SHALL pulse high for exactly one cycle, registered, in the first IDLE cycle after BT.
REQ-026 With k = max(entries popped, 1), bt_done SHALL be high k cycles after the acceptance cycle.
REQ-027 bt_found, bt_num and bt_val SHALL hold their values until the next bt_done.
REQ-028 NOP, and cmd_valid low, SHALL change no state.
REQ-029 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), combinationally from count.
REQ-030 top_* SHALL reflect the entry at count-1 combinationally, with no added latency.
REQ-031 A PUSH with cmd_num=0 or cmd_num>NUM_LITERALS SHALL be treated as overflow: dropped, with err_overflow pulsed.

Reset
REQ-032 rst SHALL force IDLE; count=0; assigned, value, top_*, bt_* = 0; bt_done=0; err_* = 0.
REQ-033 rst asserted in BT SHALL abort the backtrack with no bt_done pulse; storage contents need not be cleared.

Configuration
REQ-034 With TRAIL_DUP_CHECK_EN defined, a PUSH of an already-assigned variable SHALL be dropped and SHALL pulse err_overflow.
REQ-035 Without TRAIL_DUP_CHECK_EN, such a PUSH SHALL be stored, and assigned/value SHALL follow the newest push.

Structure
REQ-036 Package common SHALL hold the trail_entry struct {num, val, dec}, the trail_op enum, and the LW/CW width helper constants.
REQ-037 Storage SHALL be a sub-module sat_trail_mem: DEPTH x trail_entry register array with write port, combinational read at an index, and no reset on contents.

Verification (NUM_LITERALS=5, DEPTH=5)
REQ-038 PUSH (3,1,dec) then PUSH (1,0,imp) -> count=2, top=(1,0,0), assigned=00101, value=00100.
REQ-039 Push 5 entries, then PUSH var 2 -> err_overflow pulses once, count stays 5, full=1.
REQ-040 Trail [(2,1,dec),(4,0,imp),(5,1,imp)], BACKTRACK -> bt_done 3 cycles after accept, bt_found=1, bt_num=2, bt_val=0, count=0, assigned=00000, cmd_ready low for 3 cycles.
REQ-041 Trail of 2 implied entries, BACKTRACK -> bt_done after 2 cycles with bt_found=0; then BACKTRACK on empty -> bt_done after 1 cycle with bt_found=0; POP on empty -> err_underflow.
REQ-042 Assert rst on the 2nd BT cycle of a 4-entry backtrack -> next cycle count=0, cmd_ready=1, no bt_done.
REQ-043 With TRAIL_DUP_CHECK_EN: PUSH var 3 twice -> second push dropped, err_overflow pulses, count=1.
